wb_grf: RTL

Writeback-stage consumer of the M/W pipeline register, merged with the general register file. Takes the latched W-stage fields, decodes the W instruction to pick and extend the writeback value, commits it to a 32×32 register array, and serves the two D-stage read ports. Also exports the W-stage write bus for hazard/forwarding logic and keeps a retired-instruction counter.

---
 rtl/mips_defs_pkg.sv | 30 +++
 rtl/wb_grf_load_ext.sv | 37 +++
 rtl/wb_grf.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS opcode/funct constants, writeback-select and load-type encodings.
package mips_defs;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] FN_JALR    = 6'h09;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC8 = 2'd2
    } wb_sel_t;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_type_t;

endpackage

// File: rtl/wb_grf_load_ext.sv
// Extracts and sign/zero-extends the addressed byte/half of the loaded word.
module load_ext
    import mips_defs::*;
(
    input  logic [31:0] dm,
    input  logic [1:0]  addr_lo,
    input  ld_type_t    ld_type,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dm[7:0];
        case (addr_lo)
            2'd1:    byte_sel = dm[15:8];
            2'd2:    byte_sel = dm[23:16];
            2'd3:    byte_sel = dm[31:24];
            default: byte_sel = dm[7:0];
        endcase
        // halves are taken as aligned; the low address bit is ignored
        half_sel = addr_lo[1] ? dm[31:16] : dm[15:0];
    end

    always_comb begin
        result = dm;
        case (ld_type)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'd0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'd0, half_sel};
            default: result = dm;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage merged with the 32x32 register file and a retired-instruction counter.
// Define GRF_BYPASS_EN to make the read ports write-through for the W-stage write.
module wb_grf
    import mips_defs::*;
#(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       a3_w,
    input  logic [31:0]      pc8_w,
    input  logic [31:0]      ao_w,
    input  logic [31:0]      dm_w,
    input  logic [31:0]      instr_w,
    input  logic [4:0]       a1,
    input  logic [4:0]       a2,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    output logic             we_w,
    output logic [31:0]      wd_w,
    output logic [CNT_W-1:0] retire_cnt
);

    logic [31:0] regs [NREG];
    logic [5:0]  opcode;
    logic [5:0]  funct;
    wb_sel_t     wb_sel;
    ld_type_t    ld_type;
    logic [31:0] mem_val;
    logic        unused_instr_bits;

    assign opcode            = instr_w[31:26];
    assign funct             = instr_w[5:0];
    assign unused_instr_bits = ^instr_w[25:6];

    // Writeback source decode
    always_comb begin
        wb_sel  = WB_ALU;
        ld_type = LD_W;
        case (opcode)
            OP_JAL: wb_sel = WB_PC8;
            OP_SPECIAL: if (funct == FN_JALR) wb_sel = WB_PC8;
            OP_LW:  wb_sel = WB_MEM;
            OP_LB:  begin wb_sel = WB_MEM; ld_type = LD_B;  end
            OP_LBU: begin wb_sel = WB_MEM; ld_type = LD_BU; end
            OP_LH:  begin wb_sel = WB_MEM; ld_type = LD_H;  end
            OP_LHU: begin wb_sel = WB_MEM; ld_type = LD_HU; end
            default: wb_sel = WB_ALU;
        endcase
    end

    load_ext u_load_ext (
        .dm      (dm_w),
        .addr_lo (ao_w[1:0]),
        .ld_type (ld_type),
        .result  (mem_val)
    );

    always_comb begin
        wd_w = ao_w;
        case (wb_sel)
            WB_MEM:  wd_w = mem_val;
            WB_PC8:  wd_w = pc8_w;
            default: wd_w = ao_w;
        endcase
    end

    assign we_w = (a3_w != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
        end else if (we_w) begin
            regs[a3_w] <= wd_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                retire_cnt <= '0;
        else if (instr_w != '0)   retire_cnt <= retire_cnt + CNT_W'(1);
    end

`ifdef GRF_BYPASS_EN
    assign rd1 = (a1 == 5'd0) ? 32'd0 : ((we_w && a1 == a3_w) ? wd_w : regs[a1]);
    assign rd2 = (a2 == 5'd0) ? 32'd0 : ((we_w && a2 == a3_w) ? wd_w : regs[a2]);
`else
    assign rd1 = (a1 == 5'd0) ? 32'd0 : regs[a1];
    assign rd2 = (a2 == 5'd0) ? 32'd0 : regs[a2];
`endif

endmodule
